input_handshake_unit: RTL and testbench
=======================================

// Module: input_handshake_unit
// PURPOSE
//  Upstream feeder of the processor's IN path. Stalls the processor (interruption) while it waits
//  on an IN instruction (processor LED high), debounces the board confirm button, then latches the
//  synchronised switch value onto IN_Data. It releases the stall for exactly one cycle per press.
//  It sits between board I/O (switches, button, LED) and the processor's IN_Data/interruption/LED ports.
// PARAMETERS
//  SW_WIDTH         16     width of switch bus; zero-extended to DATA_WIDTH
//  DATA_WIDTH       32     width of IN_Data
//  DEBOUNCE_CYCLES  50000  consecutive stable samples required for press and for release (>=2)
// PORTS
//  clock        in   1           system clock, all state on rising edge
//  reset        in   1           asynchronous, active-high reset
//  waitRequest  in   1           processor LED output; high = IN instruction waiting for data
//  button       in   1           raw confirm button, active-high, asynchronous, bouncy
//  switches     in   SW_WIDTH    raw switch bus, asynchronous
//  interruption out  1           to processor; high = hold execution
//  IN_Data      out  DATA_WIDTH  to processor IN_Data; latched operand
//  dataValid    out  1           one-cycle pulse, coincident with stall release
//  waitingLED   out  1           board LED; high while a press is awaited or being debounced
// BEHAVIOUR
//  - One clock and one reset. Reset is asynchronous and active-high.
//  - Synchronisers: button and switches each pass through 2 flops (btn_s, sw_s) before use.
//    This adds 2 cycles of input latency. The synchroniser flops reset to 0.
//  - Reset values: state=IDLE, counter=0, IN_Data=0, dataValid=0, waitingLED=0.
//    interruption=waitRequest, because it is combinational.
//  - interruption = waitRequest & (state != DELIVER). It is the only combinational output.
//  - Counter: $clog2(DEBOUNCE_CYCLES) bits, saturates at DEBOUNCE_CYCLES-1, never wraps.
//  - FSM, 5 states, 3-bit encoding:
//    IDLE:      waitRequest=1 & btn_s=0 -> ARMED.
//               A button already held when the request arrives is not accepted until it is released.
//    ARMED:     waitingLED=1. waitRequest=0 -> IDLE. btn_s=1 -> DEB_PRESS, counter=0.
//    DEB_PRESS: waitingLED=1. waitRequest=0 -> IDLE, no latch (abort has priority).
//               btn_s=0 -> ARMED, counter=0.
//               btn_s=1 & counter==DEBOUNCE_CYCLES-1 -> IN_Data <= {zeros, sw_s}, go to DELIVER.
//               Otherwise counter++.
//    DELIVER:   exactly 1 cycle. dataValid=1, interruption=0.
//               The processor consumes IN_Data in this cycle. Next state is RELEASE, counter=0.
//    RELEASE:   waitingLED=0. btn_s=1 -> counter=0.
//               btn_s=0 & counter==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise counter++.
//               A new waitRequest here keeps the processor stalled (interruption=1).
//               The request is not armed until the button is released and IDLE is reached.
//  - Output registers: dataValid and waitingLED are registered.
//    dataValid is high in the DELIVER cycle only. waitingLED is asserted in the cycle after entry to ARMED.
//  - IN_Data holds its value until the next DELIVER. It is not cleared on waitRequest fall.
//  - Latency: last bounce edge -> DELIVER = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//  - Mid-operation reset: any state returns to IDLE asynchronously.
//    The IN_Data and counter registers are cleared. No dataValid pulse is emitted.
//  - Back-to-back IN instructions: each one requires its own press-release cycle. One press never feeds two INs.
// TESTING (bench uses DEBOUNCE_CYCLES=4, SW_WIDTH=16)
//  1. reset=1 with waitRequest=1 -> interruption=1, IN_Data=0, dataValid=0, waitingLED=0.
//     Release reset, btn=0 -> ARMED, waitingLED=1.
//  2. sw=16'h00A5, waitRequest=1, clean press held 10 cycles -> 2+4+1 cycles later a single cycle has
//     dataValid=1, interruption=0, IN_Data=32'h000000A5. interruption=1 again afterwards while waitRequest=1.
//  3. Bouncy press (1,0,1,1,0,1,1,1,1...) -> no latch until 4 consecutive synced 1s.
//     Exactly one dataValid pulse. IN_Data equals sw_s at the latch cycle.
//  4. Button held across DELIVER, second waitRequest=1 immediately -> no second dataValid.
//     interruption stays 1 until release is debounced and a new press is debounced.
//  5. waitRequest drops during DEB_PRESS (counter=2) -> return to IDLE, no dataValid.
//     IN_Data keeps its previous value, waitingLED=0.
//  6. Assert reset in DEB_PRESS with sw=16'hFFFF -> IN_Data=0, state IDLE, no pulse.
//     After reset, a fresh press latches 32'h0000FFFF.

Source files
------------

// File: rtl/input_handshake_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : input_handshake_unit_if
//  Brief    : Signal bundle between the board/processor side and the IN-path
//             handshake unit (request, button, switches, stall, operand).
//  Revision : 1.0  initial release
// ============================================================================
interface input_handshake_unit_if #(
  parameter int SW_WIDTH   = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  waitRequest;
  logic                  button;
  logic [SW_WIDTH-1:0]   switches;
  logic                  interruption;
  logic [DATA_WIDTH-1:0] IN_Data;
  logic                  dataValid;
  logic                  waitingLED;

  // Handshake unit side
  modport slave (
    input  waitRequest,
    input  button,
    input  switches,
    output interruption,
    output IN_Data,
    output dataValid,
    output waitingLED
  );

  // Board / processor side
  modport master (
    output waitRequest,
    output button,
    output switches,
    input  interruption,
    input  IN_Data,
    input  dataValid,
    input  waitingLED
  );
endinterface
`default_nettype wire

// File: rtl/input_handshake_unit.sv
`default_nettype none
// ============================================================================
//  Module   : input_handshake_unit
//  Brief    : Stalls the processor while an IN instruction waits, debounces the
//             confirm button, latches the synchronised switches onto IN_Data
//             and releases the stall for exactly one cycle per press.
//  Revision : 1.0  initial release
// ============================================================================
module input_handshake_unit #(
  parameter int SW_WIDTH        = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input_handshake_unit_if.slave bus
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_ARMED     = 3'd1;
  localparam logic [2:0] c_DEB_PRESS = 3'd2;
  localparam logic [2:0] c_DELIVER   = 3'd3;
  localparam logic [2:0] c_RELEASE   = 3'd4;

  logic                  r_btnMeta;
  logic                  r_btnSync;
  logic [SW_WIDTH-1:0]   r_swMeta;
  logic [SW_WIDTH-1:0]   r_swSync;

  logic [2:0]            r_state;
  logic [2:0]            w_nextState;
  logic [c_CNT_W-1:0]    r_count;
  logic                  w_cntClear;
  logic                  w_cntInc;
  logic                  w_latch;

  logic [DATA_WIDTH-1:0] r_inData;
  logic                  r_dataValid;
  logic                  r_waitingLED;
  logic                  w_dataValidNext;
  logic                  w_waitingLEDNext;

  // Two-flop synchronisers for the asynchronous button and switch inputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_btnMeta <= 1'b0;
      r_btnSync <= 1'b0;
      r_swMeta  <= '0;
      r_swSync  <= '0;
    end else begin
      r_btnMeta <= bus.button;
      r_btnSync <= r_btnMeta;
      r_swMeta  <= bus.switches;
      r_swSync  <= r_swMeta;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and counter/latch control; an abort by waitRequest beats a completing debounce
  always_comb begin
    w_nextState = r_state;
    w_cntClear  = 1'b0;
    w_cntInc    = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      c_IDLE: begin
        // A button still held from before the request must be released first
        if (bus.waitRequest && !r_btnSync) begin
          w_nextState = c_ARMED;
        end
      end
      c_ARMED: begin
        if (!bus.waitRequest) begin
          w_nextState = c_IDLE;
        end else if (r_btnSync) begin
          w_nextState = c_DEB_PRESS;
          w_cntClear  = 1'b1;
        end
      end
      c_DEB_PRESS: begin
        if (!bus.waitRequest) begin
          w_nextState = c_IDLE;
        end else if (!r_btnSync) begin
          w_nextState = c_ARMED;
          w_cntClear  = 1'b1;
        end else if (r_count == c_CNT_MAX) begin
          w_nextState = c_DELIVER;
          w_latch     = 1'b1;
        end else begin
          w_cntInc = 1'b1;
        end
      end
      c_DELIVER: begin
        w_nextState = c_RELEASE;
        w_cntClear  = 1'b1;
      end
      c_RELEASE: begin
        if (r_btnSync) begin
          w_cntClear = 1'b1;
        end else if (r_count == c_CNT_MAX) begin
          w_nextState = c_IDLE;
        end else begin
          w_cntInc = 1'b1;
        end
      end
      default: begin
        w_nextState = c_IDLE;
      end
    endcase
  end

  // Output decode: dataValid lines up with the DELIVER cycle, LED trails the state by one cycle
  always_comb begin
    w_dataValidNext  = (w_nextState == c_DELIVER);
    w_waitingLEDNext = (r_state == c_ARMED) || (r_state == c_DEB_PRESS);
  end

  // Registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dataValid  <= 1'b0;
      r_waitingLED <= 1'b0;
    end else begin
      r_dataValid  <= w_dataValidNext;
      r_waitingLED <= w_waitingLEDNext;
    end
  end

  // Saturating debounce counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_cntClear) begin
      r_count <= '0;
    end else if (w_cntInc && (r_count != c_CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Operand latch; holds until the next delivery
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inData <= '0;
    end else if (w_latch) begin
      r_inData <= DATA_WIDTH'(r_swSync);
    end
  end

  assign bus.interruption = bus.waitRequest & (r_state != c_DELIVER);
  assign bus.IN_Data      = r_inData;
  assign bus.dataValid    = r_dataValid;
  assign bus.waitingLED   = r_waitingLED;

endmodule
`default_nettype wire

// File: tb/tb_input_handshake_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_handshake_unit
//  Brief    : Directed scenarios with a queue-based scoreboard for the IN-path
//             handshake unit (DEBOUNCE_CYCLES = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_input_handshake_unit;

  localparam int c_SW_W  = 16;
  localparam int c_DATA_W = 32;
  localparam int c_DEB    = 4;
  localparam int c_LAT    = 2 + c_DEB + 1;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cycleCnt = 0;
  int lastPulseCycle = 0;
  logic [31:0] expQ[$];

  input_handshake_unit_if #(.SW_WIDTH(c_SW_W), .DATA_WIDTH(c_DATA_W)) bus ();

  input_handshake_unit #(
    .SW_WIDTH       (c_SW_W),
    .DATA_WIDTH     (c_DATA_W),
    .DEBOUNCE_CYCLES(c_DEB)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every dataValid pulse must match the oldest expected operand
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.dataValid === 1'b1) begin
        pulses++;
        lastPulseCycle = cycleCnt;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got dataValid=1 IN_Data=%h expected no pulse", bus.IN_Data);
        end else begin
          e = expQ.pop_front();
          check("deliver_data", bus.IN_Data, e);
          check("deliver_intr_low", {31'd0, bus.interruption}, 32'd0);
        end
      end
    end
  end

  initial begin
    int t0;
    int p0;
    logic ok;

    rst = 1'b1;
    bus.waitRequest = 1'b1;
    bus.button = 1'b0;
    bus.switches = 16'h00A5;

    // 1. reset state
    tick(2);
    check("rst_intr", {31'd0, bus.interruption}, 32'd1);
    check("rst_data", bus.IN_Data, 32'd0);
    check("rst_valid", {31'd0, bus.dataValid}, 32'd0);
    check("rst_led", {31'd0, bus.waitingLED}, 32'd0);
    rst = 1'b0;
    tick(3);
    check("armed_led", {31'd0, bus.waitingLED}, 32'd1);

    // 2. clean press
    p0 = pulses;
    expQ.push_back(32'h0000_00A5);
    bus.button = 1'b1;
    t0 = cycleCnt;
    tick(10);
    check("t2_pulses", pulses - p0, 1);
    check("t2_latency", lastPulseCycle - t0, c_LAT);
    check("t2_intr_after", {31'd0, bus.interruption}, 32'd1);
    bus.button = 1'b0;
    tick(12);

    // 3. bouncy press, then 4. held across DELIVER with an immediate second request
    p0 = pulses;
    bus.switches = 16'h1234;
    tick(3);
    expQ.push_back(32'h0000_1234);
    bus.button = 1'b1; tick(1);
    bus.button = 1'b0; tick(1);
    bus.button = 1'b1; tick(1);
    bus.button = 1'b1; tick(1);
    bus.button = 1'b0; tick(1);
    bus.button = 1'b1;
    t0 = cycleCnt;
    tick(12);
    check("t3_pulses", pulses - p0, 1);
    check("t3_latency", lastPulseCycle - t0, c_LAT);

    p0 = pulses;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      ok &= bus.interruption;
    end
    check("t4_intr_held", {31'd0, ok}, 32'd1);
    check("t4_no_pulse", pulses - p0, 0);
    bus.button = 1'b0;
    bus.switches = 16'h0F0F;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      ok &= bus.interruption;
    end
    check("t4_intr_release", {31'd0, ok}, 32'd1);
    check("t4_led_rearmed", {31'd0, bus.waitingLED}, 32'd1);
    expQ.push_back(32'h0000_0F0F);
    bus.button = 1'b1;
    tick(12);
    check("t4_second_pulse", pulses - p0, 1);
    bus.button = 1'b0;
    tick(12);

    // 5. request withdrawn mid-debounce (counter at 2)
    p0 = pulses;
    bus.switches = 16'hBEEF;
    tick(3);
    bus.button = 1'b1;
    tick(5);
    bus.waitRequest = 1'b0;
    tick(10);
    check("t5_no_pulse", pulses - p0, 0);
    check("t5_data_kept", bus.IN_Data, 32'h0000_0F0F);
    check("t5_led", {31'd0, bus.waitingLED}, 32'd0);
    check("t5_intr", {31'd0, bus.interruption}, 32'd0);
    bus.button = 1'b0;
    tick(4);

    // 6. reset during debounce, then fresh press
    p0 = pulses;
    bus.waitRequest = 1'b1;
    bus.switches = 16'hFFFF;
    tick(6);
    bus.button = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    check("t6_rst_data", bus.IN_Data, 32'd0);
    check("t6_rst_valid", {31'd0, bus.dataValid}, 32'd0);
    check("t6_rst_led", {31'd0, bus.waitingLED}, 32'd0);
    check("t6_rst_intr", {31'd0, bus.interruption}, 32'd1);
    bus.button = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    check("t6_no_pulse", pulses - p0, 0);
    expQ.push_back(32'h0000_FFFF);
    bus.button = 1'b1;
    tick(12);
    check("t6_fresh_pulse", pulses - p0, 1);
    bus.button = 1'b0;
    tick(4);

    check("queue_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
